// File: rtl/slice_pkg.sv
// Shared definitions for the slice controller and the slice testbench.
package slice_pkg;

  // Controller phases of one job: idle, weight load, image stream,
  // result drain and a one-cycle completion state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } slice_state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_ctrl.sv
// Sequences one MAC slice through a job: load one weight per MAC,
// stream the image words, then wait for as many results as image words.
module slice_ctrl
  import slice_pkg::*;
#(
  parameter int MAC_NB       = 3,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IMAGE_WIDTH  = 16,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [WEIGHT_WIDTH-1:0]       wgt_in,
  input  logic                          wgt_in_valid,
  output logic                          wgt_in_ready,
  output logic [WEIGHT_WIDTH-1:0]       weight,
  output logic [MAC_NB-1:0]             weight_valid,
  input  logic [IMAGE_WIDTH*MAC_NB-1:0] img_in,
  input  logic                          img_in_valid,
  output logic                          img_in_ready,
  output logic [IMAGE_WIDTH*MAC_NB-1:0] image,
  output logic                          image_valid,
  input  logic                          result_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int                   IDX_W    = idx_width(MAC_NB);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(MAC_NB - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  slice_state_t         state;
  slice_state_t         state_next;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] img_cnt;
  logic [LEN_WIDTH-1:0] res_cnt;
  logic [LEN_WIDTH-1:0] res_cnt_next;
  logic [IDX_W-1:0]     wgt_idx;
  logic                 cfg_acc;
  logic                 wgt_acc;
  logic                 img_acc;
  logic                 last_wgt;
  logic                 last_img;
  logic                 res_inc;

  // Ready signals come straight from state and counters so a source sees
  // them in the same cycle; img_cnt < len_q keeps the count from wrapping.
  assign cfg_ready    = (state == IDLE);
  assign wgt_in_ready = (state == LOAD);
  assign img_in_ready = (state == STREAM) && (img_cnt < len_q);

  assign cfg_acc  = cfg_valid && cfg_ready;
  assign wgt_acc  = wgt_in_valid && wgt_in_ready;
  assign img_acc  = img_in_valid && img_in_ready;
  assign last_wgt = wgt_acc && (wgt_idx == LAST_IDX);
  assign last_img = img_acc && (img_cnt == len_q - LEN_ONE);

  // Results only count while a job is streaming or draining, and the count
  // stops at the job length so stray extra pulses cannot overflow it.
  assign res_inc      = result_valid && ((state == STREAM) || (state == DRAIN))
                        && (res_cnt < len_q);
  assign res_cnt_next = res_inc ? (res_cnt + LEN_ONE) : res_cnt;

  // Next-state decode; DRAIN looks at the updated result count so the job
  // finishes in the same edge that takes the final result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_acc) state_next = LOAD;
      LOAD:    if (last_wgt) state_next = (len_q != '0) ? STREAM : DONE;
      STREAM:  if (last_img) state_next = DRAIN;
      DRAIN:   if (res_cnt_next == len_q) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job length and the weight, image and result counters; a new job
  // starts them all from zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q   <= '0;
      img_cnt <= '0;
      res_cnt <= '0;
      wgt_idx <= '0;
    end else if (cfg_acc) begin
      len_q   <= cfg_len;
      img_cnt <= '0;
      res_cnt <= '0;
      wgt_idx <= '0;
    end else begin
      if (wgt_acc) begin
        wgt_idx <= last_wgt ? '0 : (wgt_idx + 1'b1);
      end
      if (img_acc) begin
        img_cnt <= img_cnt + LEN_ONE;
      end
      res_cnt <= res_cnt_next;
    end
  end

  // Registered slice-facing outputs: each accepted word is forwarded one
  // cycle later, data registers hold between transfers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      weight       <= '0;
      weight_valid <= '0;
      image        <= '0;
      image_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      weight_valid <= wgt_acc ? (MAC_NB'(1) << wgt_idx) : '0;
      if (wgt_acc) begin
        weight <= wgt_in;
      end
      image_valid <= img_acc;
      if (img_acc) begin
        image <= img_in;
      end
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

endmodule
